// File: rtl/dual_port_sync_ram_pkg.sv
// Shared types and helpers for the simple dual-port synchronous RAM.
// Holds the sequencer state encoding, read-during-write mode codes and byte-lane merge.
package dual_port_sync_ram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // One byte lane of a byte-enabled write: the enabled lane takes new data, others keep old.
  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: sweeps every word to zero, then hands the array to the user ports.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | clear sweep running; one word zeroed per cycle, ports ignored
// ST_READY | sweep done; user write/read ports own the array
module dpram_clear_seq
  import dual_port_sync_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] clear_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      clear_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (clear_cnt == LAST_ADDR) begin
        state     <= ST_READY;
        clear_cnt <= '0;
      end else begin
        clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  assign init_busy = (state == ST_INIT);
  assign clr_we    = init_busy;
  assign clr_addr  = clear_cnt;

endmodule

// File: rtl/dual_port_sync_ram.sv
// Simple dual-port synchronous RAM with byte enables, selectable read-during-write and clear-on-reset.
// Define DPRAM_OUT_REG_EN to add a registered output stage (read latency 2 instead of 1).
module dual_port_sync_ram
  import dual_port_sync_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;

  dpram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .init_busy (init_busy),
    .clr_addr  (clr_addr),
    .clr_we    (clr_we)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      clr_idx;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_hit;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign clr_idx     = clr_addr[IDX_W-1:0];
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
  assign wr_hit      = wr_en & ~init_busy & wr_in_range;
  assign rd_ok       = rd_en & ~init_busy;
  assign wr_old      = mem[wr_idx];

  for (genvar b = 0; b < BE_WIDTH; b++) begin : g_lane
    assign wr_merged[8*b +: 8] = merge_byte(wr_old[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
  end

  // Array has no reset; the clear sweep owns the write port while init_busy is high.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_hit) begin
      mem[wr_idx] <= wr_merged;
    end
  end

  always_comb begin
    rd_word = mem[rd_idx];
    if (RDW_MODE == RDW_WRITE_FIRST && wr_hit && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  logic [DATA_WIDTH-1:0] rd_data_a;
  logic                  rd_valid_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a  <= '0;
      rd_valid_a <= 1'b0;
    end else begin
      rd_valid_a <= rd_ok;
      if (rd_ok) begin
        rd_data_a <= rd_in_range ? rd_word : '0;
      end
    end
  end

`ifdef DPRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_a;
      if (rd_valid_a) begin
        rd_data_q <= rd_data_a;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`else
  assign rd_data  = rd_data_a;
  assign rd_valid = rd_valid_a;
`endif

endmodule
